// File: rtl/count_capture_if.sv
// Read-side bundle of count_capture: FWFT valid/ready port, fill level and sticky overflow.
// master = the capture block, slave = the consumer.
interface count_capture_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          rd_valid;
    logic          rd_ready;
    logic [15:0]   rd_data;
    logic [LW-1:0] level;
    logic          overflow;
    logic          ovf_clr;

    modport master (
        output rd_valid,
        output rd_data,
        output level,
        output overflow,
        input  rd_ready,
        input  ovf_clr
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        input  level,
        input  overflow,
        output rd_ready,
        output ovf_clr
    );
endinterface

// File: rtl/count_capture.sv
// Timestamp capture: synchronizes event_in, detects selected edges, pushes `count` into a FWFT FIFO.
// Optional build macro COUNT_CAPTURE_DELTA_EN stores the distance from the previous event instead.
module count_capture #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [15:0]           count,
    input  logic                  event_in,
    input  logic [1:0]            edge_sel,
    count_capture_if.master       rd
);
    localparam int               AW         = $clog2(DEPTH);
    localparam int               LW         = AW + 1;
    localparam logic [LW-1:0]    FULL_LEVEL = LW'(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise;
    logic                   fall;
    logic                   detect;
    logic [15:0]            capture_value;

    logic [15:0]            mem [DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [LW-1:0]          level_q;
    logic [LW-1:0]          level_d;
    logic                   overflow_q;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   drop;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall   = ~sync_q[SYNC_STAGES-1] & hist_q;
    assign detect = (edge_sel[0] & rise) | (edge_sel[1] & fall);

`ifdef COUNT_CAPTURE_DELTA_EN
    logic [15:0] base_q;

    // Base follows every detected edge, dropped or not, so deltas are event-to-event.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            base_q <= 16'h0000;
        end else if (detect) begin
            base_q <= count;
        end
    end

    assign capture_value = count - base_q;
`else
    assign capture_value = count;
`endif

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign pop   = ~empty & rd.rd_ready;
    assign push  = detect & (~full | pop);
    assign drop  = detect & full & ~pop;

    // NOTE: storage has no reset; empty is tracked by level_q and rd_data is forced to 0 when empty.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= capture_value;
        end
    end

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            level_q <= level_d;
            // A drop on the same edge as ovf_clr keeps the flag set.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (rd.ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign rd.rd_valid = ~empty;
    assign rd.rd_data  = empty ? 16'h0000 : mem[rd_ptr_q];
    assign rd.level    = level_q;
    assign rd.overflow = overflow_q;

endmodule

// File: tb/tb_count_capture.sv
// Directed bench for count_capture: expected captures are queued when events are driven and
// compared as the consumer pops them; level/overflow/reset behaviour is checked directly.
module tb_count_capture;
    logic        clock;
    logic        clear;
    logic [15:0] count;
    logic        event_in;
    logic [1:0]  edge_sel;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] sb [$];
    logic [15:0] tb_base;

    count_capture_if #(.DEPTH(4)) bus ();

    count_capture #(.DEPTH(4), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .clear    (clear),
        .count    (count),
        .event_in (event_in),
        .edge_sel (edge_sel),
        .rd       (bus.master)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance n edges; inputs change 1 time unit after each edge, count acting as the free-running counter.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            count = count + 16'd1;
        end
    endtask

    // Drive event_in; a detected edge is captured SYNC_STAGES+1 edges later, i.e. at count+2.
    task automatic ev(input logic v, input bit detected, input bit pushed);
        logic [15:0] cap;
        logic [15:0] e;
        event_in = v;
        if (detected) begin
            cap = count + 16'd2;
`ifdef COUNT_CAPTURE_DELTA_EN
            e       = cap - tb_base;
            tb_base = cap;
`else
            e = cap;
`endif
            if (pushed) sb.push_back(e);
        end
    endtask

    task automatic tick_until(input logic [15:0] target);
        for (int g = 0; g < 300 && count != target; g++) tick(1);
    endtask

    // Consumer-side scoreboard: every accepted pop must match the oldest queued expectation.
    always @(negedge clock) begin
        if (clear === 1'b1 && bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("pop_with_empty_scoreboard", sb.size(), 1);
            end else begin
                check("pop_data", bus.rd_data, sb.pop_front());
            end
        end
    end

    initial begin
        clear       = 1'b0;
        count       = 16'h0000;
        event_in    = 1'b0;
        edge_sel    = 2'b00;
        bus.rd_ready = 1'b0;
        bus.ovf_clr  = 1'b0;
        tb_base     = 16'h0000;

        tick(2);
        check("rst_level", bus.level, 0);
        check("rst_valid", bus.rd_valid, 0);
        check("rst_data", bus.rd_data, 16'h0000);
        check("rst_overflow", bus.overflow, 0);
        clear = 1'b1;
        tick(2);

        // Rising capture at count 0x0100 -> 0x0102; following fall ignored.
        edge_sel = 2'b01;
        count    = 16'h0100;
        ev(1'b1, 1'b1, 1'b1);
        tick(2);
        check("rise_not_yet_valid", bus.rd_valid, 0);
        tick(1);
        check("rise_valid", bus.rd_valid, 1);
        check("rise_data", bus.rd_data, 16'h0102);
        ev(1'b0, 1'b0, 1'b0);
        tick(5);
        check("fall_ignored_level", bus.level, 1);
        bus.rd_ready = 1'b1;
        tick(1);
        bus.rd_ready = 1'b0;
        check("rise_drained", bus.level, 0);

        // Disabled edge select never captures.
        edge_sel = 2'b00;
        ev(1'b1, 1'b0, 1'b0);
        tick(3);
        ev(1'b0, 1'b0, 1'b0);
        tick(4);
        check("disabled_level", bus.level, 0);
        check("disabled_valid", bus.rd_valid, 0);

        // Both edges, back-to-back, six captures into a 4-deep FIFO.
        edge_sel = 2'b11;
        ev(1'b1, 1'b1, 1'b1); tick(1);
        ev(1'b0, 1'b1, 1'b1); tick(1);
        ev(1'b1, 1'b1, 1'b1); tick(1);
        ev(1'b0, 1'b1, 1'b1); tick(1);
        ev(1'b1, 1'b1, 1'b0); tick(1);
        ev(1'b0, 1'b1, 1'b0); tick(4);
        check("full_level", bus.level, 4);
        check("full_overflow", bus.overflow, 1);
        check("full_head", bus.rd_data, sb[0]);
        tick(1);
        check("full_head_stable", bus.rd_data, sb[0]);
        bus.ovf_clr = 1'b1;
        tick(1);
        bus.ovf_clr = 1'b0;
        check("ovf_cleared", bus.overflow, 0);

        // Full FIFO with a pop on the capture edge: push accepted, no overflow.
        ev(1'b1, 1'b1, 1'b1);
        tick(2);
        bus.rd_ready = 1'b1;
        tick(1);
        bus.rd_ready = 1'b0;
        check("full_pop_level", bus.level, 4);
        check("full_pop_overflow", bus.overflow, 0);
        bus.rd_ready = 1'b1;
        tick(4);
        bus.rd_ready = 1'b0;
        check("full_pop_drained", bus.level, 0);
        check("full_pop_sb_empty", sb.size(), 0);

        // Drain order: captures at 0x0010, 0x0020, 0x0030, read one per cycle.
        count = 16'h000E;
        ev(1'b0, 1'b1, 1'b1);
        tick_until(16'h001E);
        ev(1'b1, 1'b1, 1'b1);
        tick_until(16'h002E);
        ev(1'b0, 1'b1, 1'b1);
        tick(3);
        check("drain_level3", bus.level, 3);
        bus.rd_ready = 1'b1;
        tick(1);
        check("drain_level2", bus.level, 2);
        tick(1);
        check("drain_level1", bus.level, 1);
        tick(1);
        bus.rd_ready = 1'b0;
        check("drain_level0", bus.level, 0);
        check("drain_valid0", bus.rd_valid, 0);
        check("drain_data0", bus.rd_data, 16'h0000);

        // Reset mid-run with three entries held and event_in high.
        ev(1'b1, 1'b1, 1'b1); tick(1);
        ev(1'b0, 1'b1, 1'b1); tick(1);
        ev(1'b1, 1'b1, 1'b1); tick(4);
        check("pre_reset_level", bus.level, 3);
        clear = 1'b0;
        #1;
        sb.delete();
        tb_base = 16'h0000;
        check("midrst_level", bus.level, 0);
        check("midrst_valid", bus.rd_valid, 0);
        check("midrst_data", bus.rd_data, 16'h0000);
        check("midrst_overflow", bus.overflow, 0);
        tick(2);
        count    = 16'hFFEE;
        edge_sel = 2'b01;
        clear    = 1'b1;
        ev(1'b1, 1'b1, 1'b1);
        tick(2);
        check("rel_not_yet_valid", bus.rd_valid, 0);
        tick(1);
        check("rel_valid", bus.rd_valid, 1);
        check("rel_data", bus.rd_data, 16'hFFF0);

        // Second event across the counter wrap, at count 0x0010.
        edge_sel = 2'b11;
        tick_until(16'h000E);
        ev(1'b0, 1'b1, 1'b1);
        tick(3);
        check("wrap_level", bus.level, 2);
        bus.rd_ready = 1'b1;
        tick(1);
`ifdef COUNT_CAPTURE_DELTA_EN
        check("wrap_second_entry", bus.rd_data, 16'h0020);
`else
        check("wrap_second_entry", bus.rd_data, 16'h0010);
`endif
        tick(1);
        bus.rd_ready = 1'b0;
        check("final_level", bus.level, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
